// File: rtl/fft_output_reader_if.sv
// Bank RAM read ports and output sample stream of the FFT output reader.
// The master view belongs to the reader; the slave view belongs to the RAMs and the consumer.
interface fft_output_reader_if #(
    parameter int N_LOG2 = 6,
    parameter int DATA_W = 16
);
    logic                  re_b0;
    logic [N_LOG2-2:0]     raddr_b0;
    logic                  re_b1;
    logic [N_LOG2-2:0]     raddr_b1;
    logic [2*DATA_W-1:0]   rdata_b0;
    logic [2*DATA_W-1:0]   rdata_b1;

    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   out_data;
    logic [N_LOG2-1:0]     out_index;
    logic                  out_last;

    modport master (
        output re_b0, raddr_b0, re_b1, raddr_b1,
        input  rdata_b0, rdata_b1,
        output out_valid, out_data, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  re_b0, raddr_b0, re_b1, raddr_b1,
        output rdata_b0, rdata_b1,
        input  out_valid, out_data, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/fft_output_reader.sv
// Reads the 64 FFT results from the two parity-interleaved banks, undoes the bit-reversed
// ordering and streams one {real, imag} sample per cycle through a 2-entry credit-managed FIFO.
module fft_output_reader #(
    parameter int N_LOG2 = 6,
    parameter int DATA_W = 16,
    parameter int BITREV = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 output_start,
    fft_output_reader_if.master  bus,
    output logic                 busy,
    output logic                 done
);

    localparam int NPTS = 1 << N_LOG2;
    localparam int AW   = N_LOG2 - 1;
    localparam int CW   = N_LOG2 + 1;
    localparam int SW   = 2 * DATA_W;
    localparam logic [CW-1:0] LAST_I = CW'(NPTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [SW-1:0]     data;
        logic [N_LOG2-1:0] index;
        logic              last;
    } entry_t;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] r;
        for (int b = 0; b < N_LOG2; b++) begin
            r[b] = v[N_LOG2-1-b];
        end
        return r;
    endfunction

    // Control state
    state_e            state_q;
    logic              start_q;
    logic              busy_q;
    logic              done_q;
    logic [CW-1:0]     issue_cnt_q;

    // Read in flight: RAM data for it appears in the current cycle
    logic              infl_q;
    logic              infl_bank_q;
    logic [N_LOG2-1:0] infl_index_q;
    logic              infl_last_q;
    logic [AW-1:0]     raddr_b0_q;
    logic [AW-1:0]     raddr_b1_q;

    // Output FIFO
    entry_t            fifo_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        fifo_cnt_q;

    // Combinational
    logic              start_edge;
    logic              push;
    logic              pop;
    logic [1:0]        credit;
    logic              issue;
    logic [N_LOG2-1:0] cur_index;
    logic [N_LOG2-1:0] pos;
    logic              sel_bank;
    logic [AW-1:0]     sel_addr;
    entry_t            push_entry;
    entry_t            head;

    assign start_edge = output_start & ~start_q;
    assign push       = infl_q;
    assign pop        = (fifo_cnt_q != 2'd0) & bus.out_ready;
    assign credit     = fifo_cnt_q + {1'b0, infl_q};

    // A slot is free if FIFO plus in-flight reads stay within the 2 entries at the next edge.
    assign issue = (state_q == S_READ) &&
                   ((credit < 2'd2) || ((credit == 2'd2) && pop));

    always_comb begin
        // NOTE: every always_comb output gets a value on every path so no latch is inferred.
        cur_index       = issue_cnt_q[N_LOG2-1:0];
        pos             = (BITREV != 0) ? bitrev(cur_index) : cur_index;
        sel_bank        = ^pos;
        sel_addr        = pos[N_LOG2-1:1];
        push_entry.data  = infl_bank_q ? bus.rdata_b1 : bus.rdata_b0;
        push_entry.index = infl_index_q;
        push_entry.last  = infl_last_q;
        head            = fifo_q[rd_ptr_q];
    end

    assign bus.re_b0     = issue & ~sel_bank;
    assign bus.re_b1     = issue &  sel_bank;
    assign bus.raddr_b0  = (issue & ~sel_bank) ? sel_addr : raddr_b0_q;
    assign bus.raddr_b1  = (issue &  sel_bank) ? sel_addr : raddr_b1_q;

    assign bus.out_valid = (fifo_cnt_q != 2'd0);
    assign bus.out_data  = head.data;
    assign bus.out_index = head.index;
    assign bus.out_last  = head.last;

    assign busy = busy_q;
    assign done = done_q;

    // Frame sequencing; busy/done are registered alongside the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            start_q <= output_start;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_q     <= S_READ;
                        busy_q      <= 1'b1;
                        issue_cnt_q <= '0;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        issue_cnt_q <= issue_cnt_q + CW'(1);
                        if (issue_cnt_q == LAST_I) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((fifo_cnt_q == 2'd0) && !infl_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Bank-select/index pipeline matching the one-cycle RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q       <= 1'b0;
            infl_bank_q  <= 1'b0;
            infl_index_q <= '0;
            infl_last_q  <= 1'b0;
            raddr_b0_q   <= '0;
            raddr_b1_q   <= '0;
        end else begin
            infl_q <= issue;
            if (issue) begin
                infl_bank_q  <= sel_bank;
                infl_index_q <= cur_index;
                infl_last_q  <= (issue_cnt_q == LAST_I);
                if (sel_bank) begin
                    raddr_b1_q <= sel_addr;
                end else begin
                    raddr_b0_q <= sel_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the FIFO storage is reset because out_data shows the head even when empty.
            for (int k = 0; k < 2; k++) begin
                fifo_q[k] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_entry;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 2'd1;
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - 2'd1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (fifo_cnt_q == 2'd2)));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_cnt_q > 2'd2));

endmodule

// File: tb/tb_fft_output_reader.sv
// Scoreboarded bench: one reader in natural-order mode, one in memory-order mode.
module tb_fft_output_reader;

    localparam int N_LOG2 = 6;
    localparam int DATA_W = 16;
    localparam int NPTS   = 64;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  index;
        logic        last;
    } sample_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_r, start_m;
    logic busy_r, done_r, busy_m, done_m;

    fft_output_reader_if #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) bus_r ();
    fft_output_reader_if #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) bus_m ();

    fft_output_reader #(.N_LOG2(N_LOG2), .DATA_W(DATA_W), .BITREV(1)) dut (
        .clk(clk), .rst_n(rst_n), .output_start(start_r),
        .bus(bus_r), .busy(busy_r), .done(done_r)
    );

    fft_output_reader #(.N_LOG2(N_LOG2), .DATA_W(DATA_W), .BITREV(0)) dut_mem (
        .clk(clk), .rst_n(rst_n), .output_start(start_m),
        .bus(bus_m), .busy(busy_m), .done(done_m)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] val   [2][NPTS];
    logic [31:0] bank0 [2][32];
    logic [31:0] bank1 [2][32];
    sample_t     exp_q [2][$];
    int          pos_q [2][$];
    int          hs_cnt [2];
    int          done_cnt [2];
    logic        stall_q [2];
    logic [31:0] stall_data [2];
    logic [5:0]  stall_idx [2];

    function automatic int rev6(input int v);
        int r = 0;
        for (int b = 0; b < 6; b++) if (v[b]) r = r | (1 << (5 - b));
        return r;
    endfunction

    function automatic int par6(input int v);
        return $countones(v[5:0]) & 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bank RAM models, one-cycle read latency
    always @(posedge clk) begin
        if (bus_r.re_b0) bus_r.rdata_b0 <= bank0[0][bus_r.raddr_b0];
        if (bus_r.re_b1) bus_r.rdata_b1 <= bank1[0][bus_r.raddr_b1];
        if (bus_m.re_b0) bus_m.rdata_b0 <= bank0[1][bus_m.raddr_b0];
        if (bus_m.re_b1) bus_m.rdata_b1 <= bank1[1][bus_m.raddr_b1];
    end

    task automatic mon(input int k, input logic re0, input logic re1,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic valid, input logic ready, input logic [31:0] data,
                       input logic [5:0] idx, input logic last, input logic dn);
        int p;
        sample_t s;
        if (re0 | re1) begin
            check($sformatf("re_onehot%0d", k), 64'(re0 & re1), 64'd0);
            if (pos_q[k].size() == 0) begin
                check($sformatf("unexpected_read%0d", k), 64'd1, 64'd0);
            end else begin
                p = pos_q[k].pop_front();
                check($sformatf("bank%0d", k), 64'(re1), 64'(par6(p)));
                check($sformatf("addr%0d", k), 64'(re1 ? a1 : a0), 64'(p >> 1));
            end
        end
        if (stall_q[k] && valid) begin
            check($sformatf("hold_data%0d", k), 64'(data), 64'(stall_data[k]));
            check($sformatf("hold_index%0d", k), 64'(idx), 64'(stall_idx[k]));
        end
        if (valid && ready) begin
            if (exp_q[k].size() == 0) begin
                check($sformatf("unexpected_sample%0d", k), 64'd1, 64'd0);
            end else begin
                s = exp_q[k].pop_front();
                check($sformatf("data%0d", k), 64'(data), 64'(s.data));
                check($sformatf("index%0d", k), 64'(idx), 64'(s.index));
                check($sformatf("last%0d", k), 64'(last), 64'(s.last));
            end
            hs_cnt[k]++;
        end
        stall_q[k]    = valid & ~ready;
        stall_data[k] = data;
        stall_idx[k]  = idx;
        if (dn) done_cnt[k]++;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, bus_r.re_b0, bus_r.re_b1, bus_r.raddr_b0, bus_r.raddr_b1, bus_r.out_valid,
                bus_r.out_ready, bus_r.out_data, bus_r.out_index, bus_r.out_last, done_r);
            mon(1, bus_m.re_b0, bus_m.re_b1, bus_m.raddr_b0, bus_m.raddr_b1, bus_m.out_valid,
                bus_m.out_ready, bus_m.out_data, bus_m.out_index, bus_m.out_last, done_m);
        end else begin
            stall_q[0] = 1'b0;
            stall_q[1] = 1'b0;
        end
    end

    // Low-then-high on output_start and the frame the reference model expects from it.
    task automatic start_frame(input int k);
        sample_t s;
        int p;
        if (k == 0) start_r = 1'b0; else start_m = 1'b0;
        @(posedge clk); #1;
        if (k == 0) start_r = 1'b1; else start_m = 1'b1;
        for (int n = 0; n < NPTS; n++) begin
            p = (k == 0) ? rev6(n) : n;
            s.data  = val[k][p];
            s.index = n[5:0];
            s.last  = (n == NPTS - 1);
            exp_q[k].push_back(s);
            pos_q[k].push_back(p);
        end
    endtask

    task automatic wait_done(input int k, input int target, input int budget);
        int n = 0;
        while (done_cnt[k] < target && n < budget) begin
            @(posedge clk); n++;
        end
        check($sformatf("done_reached%0d", k), 64'(done_cnt[k]), 64'(target));
        repeat (3) @(negedge clk);
        check($sformatf("done_once%0d", k), 64'(done_cnt[k]), 64'(target));
        check($sformatf("busy_low%0d", k), 64'((k == 0) ? busy_r : busy_m), 64'd0);
        check($sformatf("queue_empty%0d", k), 64'(exp_q[k].size()), 64'd0);
    endtask

    task automatic wait_hs(input int k, input int target, input int budget);
        int n = 0;
        while (hs_cnt[k] < target && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check($sformatf("hs_reached%0d", k), 64'(hs_cnt[k] >= target), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_re"}, 64'({bus_r.re_b0, bus_r.re_b1}), 64'd0);
        check({tag, "_raddr"}, 64'({bus_r.raddr_b0, bus_r.raddr_b1}), 64'd0);
        check({tag, "_valid_last"}, 64'({bus_r.out_valid, bus_r.out_last}), 64'd0);
        check({tag, "_index"}, 64'(bus_r.out_index), 64'd0);
        check({tag, "_data"}, 64'(bus_r.out_data), 64'd0);
        check({tag, "_busy_done"}, 64'({busy_r, done_r}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dc;
        int n;
        start_r = 1'b0;
        start_m = 1'b0;
        bus_r.out_ready = 1'b0;
        bus_m.out_ready = 1'b0;
        stall_q[0] = 1'b0;
        stall_q[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            hs_cnt[k] = 0;
            done_cnt[k] = 0;
            for (int p = 0; p < NPTS; p++) begin
                val[k][p] = $urandom;
                if (par6(p) == 1) bank1[k][p >> 1] = val[k][p];
                else              bank0[k][p >> 1] = val[k][p];
            end
        end

        // Reset state
        #1;
        check_zero("reset");
        #20 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: full frame, latency and first addresses
        bus_r.out_ready = 1'b1;
        start_frame(0);
        @(negedge clk);
        check("pre_e0_re", 64'(bus_r.re_b0 | bus_r.re_b1), 64'd0);
        @(negedge clk);
        check("e0_busy", 64'(busy_r), 64'd1);
        check("e0_re_b0_addr", 64'({bus_r.re_b0, bus_r.raddr_b0}), 64'({1'b1, 5'd0}));
        check("e0_valid", 64'(bus_r.out_valid), 64'd0);
        @(negedge clk);
        check("e1_re_b1_addr", 64'({bus_r.re_b1, bus_r.raddr_b1}), 64'({1'b1, 5'd16}));
        check("e1_valid", 64'(bus_r.out_valid), 64'd0);
        @(negedge clk);
        check("e2_valid", 64'(bus_r.out_valid), 64'd1);
        check("e2_re_b1_addr", 64'({bus_r.re_b1, bus_r.raddr_b1}), 64'({1'b1, 5'd8}));
        wait_done(0, 1, 300);
        check("frame1_count", 64'(hs_cnt[0]), 64'd64);

        // 2: backpressure holding sample 10 at the head
        base = hs_cnt[0];
        start_frame(0);
        wait_hs(0, base + 10, 300);
        bus_r.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 64'(bus_r.out_valid), 64'd1);
            check("stall_index", 64'(bus_r.out_index), 64'd10);
            check("stall_no_read", 64'(bus_r.re_b0 | bus_r.re_b1), 64'd0);
        end
        @(posedge clk); #1;
        bus_r.out_ready = 1'b1;
        wait_done(0, 2, 300);
        check("frame2_count", 64'(hs_cnt[0] - base), 64'd64);

        // 3: start held high gives one frame; re-raise gives another
        base = hs_cnt[0];
        start_frame(0);
        repeat (300) @(posedge clk);
        check("held_done", 64'(done_cnt[0]), 64'd3);
        check("held_count", 64'(hs_cnt[0] - base), 64'd64);
        base = hs_cnt[0];
        start_frame(0);
        wait_done(0, 4, 300);
        check("reraise_count", 64'(hs_cnt[0] - base), 64'd64);

        // 4: extra start edge during READ is ignored
        base = hs_cnt[0];
        start_frame(0);
        repeat (4) @(posedge clk);
        #1 start_r = 1'b0;
        @(posedge clk); #1;
        start_r = 1'b1;
        wait_done(0, 5, 300);
        repeat (100) @(posedge clk);
        check("retrigger_done", 64'(done_cnt[0]), 64'd5);
        check("retrigger_count", 64'(hs_cnt[0] - base), 64'd64);

        // 5: asynchronous reset mid-frame
        base = hs_cnt[0];
        start_frame(0);
        wait_hs(0, base + 20, 300);
        #1;
        rst_n = 1'b0;
        start_r = 1'b0;
        exp_q[0].delete();
        pos_q[0].delete();
        #1;
        check_zero("midreset");
        #4 rst_n = 1'b1;
        dc = done_cnt[0];
        repeat (20) begin
            @(negedge clk);
            check("idle_no_read", 64'(bus_r.re_b0 | bus_r.re_b1), 64'd0);
        end
        check("idle_state", 64'({busy_r, bus_r.out_valid}), 64'd0);
        check("no_done_after_reset", 64'(done_cnt[0]), 64'(dc));

        // 6: memory order with random backpressure
        start_frame(1);
        n = 0;
        while (done_cnt[1] < 1 && n < 2000) begin
            @(posedge clk); #1;
            bus_m.out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        bus_m.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("mem_done", 64'(done_cnt[1]), 64'd1);
        check("mem_count", 64'(hs_cnt[1]), 64'd64);
        check("mem_queue_empty", 64'(exp_q[1].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_output_reader.md
Name: fft_output_reader

Overview:
- Output-side counterpart of the FFT control block. After the last butterfly stage, it reads the 64 results out of the two 32-entry memory banks.
- It undoes the parity bank interleave and the bit-reversed in-place ordering, then streams one complex sample per cycle on a valid/ready interface.
- It sits between the bank RAM read ports and the downstream consumer, and is triggered by the control block's output_start.

Parameters:
- N_LOG2, 6, log2 of FFT points (64); bank depth = 2**(N_LOG2-1)
- DATA_W, 16, width of each real/imag component; a sample is 2*DATA_W bits
- BITREV, 1, 1 = emit natural order (read position bitrev(n)); 0 = emit memory order (position n)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- output_start  in  1  level from control block; a rising edge starts one frame
- re_b0  out  1  read enable, bank 0
- raddr_b0  out  N_LOG2-1  read address, bank 0
- re_b1  out  1  read enable, bank 1
- raddr_b1  out  N_LOG2-1  read address, bank 1
- rdata_b0  in  2*DATA_W  bank 0 read data, valid the cycle after re_b0
- rdata_b1  in  2*DATA_W  bank 1 read data, valid the cycle after re_b1
- out_valid  out  1  out_data/out_index/out_last valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_data  out  2*DATA_W  sample {real, imag}
- out_index  out  N_LOG2  frequency index n of out_data
- out_last  out  1  high with n = 63
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last sample handshakes

Behaviour:
- Reset (async, rst_n=0): state IDLE; issue counter=0; output counter=0; FIFO empty; inflight=0; start_q=0.
- Reset values of outputs: re_b0=re_b1=0, raddr_b0=raddr_b1=0, out_valid=0, out_last=0, out_index=0, out_data=0, busy=0, done=0.
- Start detection: start_q <= output_start; start_edge = output_start & ~start_q. start_edge is honoured only in IDLE; it is ignored in any other state. Holding output_start high yields exactly one frame; a new frame needs a low-then-high transition.
- FSM:
  - IDLE -> READ on start_edge.
  - READ -> DRAIN after the issue with issue counter = 63.
  - DRAIN -> DONE when the FIFO is empty and inflight = 0.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
  - busy=1 in READ and DRAIN.
- Address mapping for issue counter i:
  - position p = BITREV ? bitrev6(i) : i
  - bank = p[5]^p[4]^p[3]^p[2]^p[1]^p[0]
  - address = p[5:1]
  - Only the selected bank's re is high; the other bank's re is 0 and its raddr holds its last value.
- Issue condition: state READ and (fifo_count + inflight < 2, or fifo_count + inflight = 2 with a pop in the same cycle). re/raddr are combinational from registered state.
- RAM latency is 1 cycle. The bank select is pipelined with inflight; read data is pushed into a 2-entry output FIFO on the following edge.
- Each FIFO entry holds {data, index, last}.
  - out_valid = FIFO non-empty; out_* come from the FIFO head.
  - out_* must stay stable while out_valid & ~out_ready.
- Throughput: 1 sample/cycle with out_ready high.
- Latency: start_edge sampled at edge E0 gives re in the cycle after E0, rdata the cycle after that, and out_valid after E2.
- Simultaneous push and pop: count unchanged. The FIFO never overflows, guaranteed by the credit rule.
- out_index = i of the sample (natural n when BITREV=1). out_last = (i == 63).
- Reset mid-frame returns to the reset state immediately. Partial data is discarded and no done pulse is produced.
- Arithmetic: counters are N_LOG2+1 bits wide; issue stops at 64, with no wrap.

Test Plan:
1. Reset, preload the banks so each entry holds its position p; output_start 0->1 with out_ready=1 -> out_valid rises 3 edges after the start edge; 64 consecutive samples; n=1 reads bank1 addr 16 (p=32), n=2 reads bank1 addr 8; out_last on n=63; done pulses once; busy drops.
2. Deassert out_ready for 5 cycles after sample n=10 -> out_data/out_index frozen at 10; re low once FIFO + inflight = 2; resuming gives 11..63 with no loss or duplicate.
3. Hold output_start high for 300 cycles -> exactly 64 samples and one done; drop and re-raise -> second identical frame.
4. Pulse output_start again during READ -> ignored, frame count stays 1.
5. Assert rst_n=0 at sample n=20 -> all outputs 0 asynchronously; after release with no start, the block stays IDLE with re_b0=re_b1=0.
6. BITREV=0 with toggling out_ready (random 50%) -> positions 0..63 in order; bank = parity(n), addr = n>>1; total 64 handshakes.
